forward_pass_sequencer: RTL and testbench
=========================================

# forward_pass_sequencer

Frame-level controller for the CNN forward-pass datapath (conv → maxpool → dense1 → dense2). It reads one 28×28 8-bit image from a synchronous image memory and streams it into the datapath with the frame, line and enable strobes. It then waits for the 160-bit class-score vector, reduces it to an argmax class with a sequential comparator, and presents the result on a valid/ready handshake. A watchdog flags a datapath that never returns a result.

## Interface
Clocking: one clock; reset is synchronous and active-high. The clock port is `clk` and the reset port is `rst`.

Parameters:
- `IMG_W`, 28: pixels per line.
- `IMG_H`, 28: lines per frame.
- `ADDR_W`, 10: image memory address width; must satisfy 2^ADDR_W ≥ IMG_W·IMG_H.
- `NUM_CLASS`, 10: number of class scores.
- `SCORE_W`, 16: width of each score, signed two's complement.
- `TIMEOUT`, 4096: cycles allowed in WAIT before the error path is taken.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `start` in 1: request one inference; sampled only in IDLE.
- `busy` out 1: high from the cycle after start is accepted until the result handshake completes.
- `mem_rd_en` out 1: image memory read strobe.
- `mem_addr` out ADDR_W: pixel address, row-major.
- `mem_rd_data` in 8: pixel data, valid 1 cycle after `mem_rd_en`.
- `fp_ima` out 8: pixel to the datapath.
- `fp_ena` out 1: pixel valid.
- `fp_frame_start` out 1: high with pixel 0.
- `fp_line_start` out 1: high with column 0 of every line.
- `fp_frame_end` out 1: high with the last pixel.
- `fp_frame_start_dim` out 1: 1-cycle pulse, one cycle before pixel 0.
- `fp_frame_end_dim` out 1: 1-cycle pulse, one cycle after the last pixel.
- `fp_valid` in 1: datapath result strobe.
- `fp_out` in NUM_CLASS·SCORE_W: class k is `fp_out[SCORE_W·k +: SCORE_W]`.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result.
- `res_class` out 4: argmax index; 4'hF on timeout.
- `res_score` out SCORE_W: winning score; 0 on timeout.
- `res_scores` out NUM_CLASS·SCORE_W: captured score vector.
- `timeout_err` out 1: qualifies `res_valid` as an error result.

## Operation
- FSM states: IDLE → PRE → STREAM → POST → WAIT → ARGMAX → HOLD → IDLE.
- **IDLE:** `start`=1 moves to PRE. `start` in any other state is ignored and is not queued.
- **PRE:** one cycle. Issues the read of address 0.
- **STREAM:**
  - Issues reads for addresses 1..N−1, where N = IMG_W·IMG_H.
  - Column and row counters wrap at IMG_W−1 and IMG_H−1.
  - The registered pixel pipeline drives `fp_*` two cycles after each read.
  - Exits to POST once the last pixel has been driven.
- **POST:** one cycle. `fp_frame_end_dim`=1.
- **WAIT:**
  - The timeout counter clears on entry and increments each cycle.
  - `fp_valid`=1 captures `fp_out` into `res_scores` and moves to ARGMAX.
  - Counter reaching TIMEOUT−1 without `fp_valid` moves to HOLD with `timeout_err`=1, `res_class`=4'hF, `res_score`=0.
  - `fp_valid` on the same cycle as the timeout wins; the result is valid, not an error.
- **ARGMAX:**
  - NUM_CLASS cycles, one signed comparison per cycle over k = 0..NUM_CLASS−1.
  - The running best is replaced only on strictly greater, so ties resolve to the lowest index.
- **HOLD:**
  - `res_valid`=1 and all `res_*` are held stable.
  - The transfer occurs on `res_valid`&&`res_ready`; the next cycle is IDLE with `res_valid`=0 and `busy`=0.
- `fp_valid` outside WAIT is ignored.
- Outputs outside STREAM: `fp_ena` and all frame/line strobes are 0. `fp_ima` holds its last value.
- **Reset:** any state goes to IDLE on the next edge. Every output resets to 0, including `mem_addr`, `fp_ima`, `res_scores` and `res_class`. Reset does not flush the datapath; the system resets both together.

## Timing
- Let S be the cycle in which `start` is sampled in IDLE.
- Reads: `mem_rd_en`=1 on S+1..S+N, with `mem_addr`=k at S+1+k.
- `busy`=1 from S+1.
- `fp_frame_start_dim` pulses at S+2.
- Pixel k is driven at S+3+k with `fp_ena`=1:
  - `fp_frame_start` at S+3;
  - `fp_line_start` at S+3+r·IMG_W;
  - `fp_frame_end` at S+N+2.
- `fp_frame_end_dim` pulses at S+N+3, the POST cycle. WAIT begins at S+N+4.
- If `fp_valid` arrives at cycle V: scores are captured at V, ARGMAX runs V+1..V+NUM_CLASS, and `res_valid` rises at V+NUM_CLASS+1.
- On timeout, `res_valid` rises at S+N+4+TIMEOUT.
- Minimum start-to-start interval is one cycle after the handshake.

## Test plan
- **Stream check:** memory holds pixel = addr mod 256; pulse `start` at cycle 10 → reads at cycles 11..794, `fp_frame_start_dim` at 12, pixel 0 (value 0x00) at 13, 28 `fp_line_start` pulses spaced 28 cycles apart, last pixel 0x0F with `fp_frame_end` at 796, `fp_frame_end_dim` at 797.
- **Argmax with tie:** in WAIT, apply `fp_valid` with scores {−5, 3, 0x7FFF, 2, 0x7FFF, 0, 0, 0, 0x8000, 1} → `res_valid` 11 cycles later with `res_class`=2, `res_score`=0x7FFF, `timeout_err`=0.
- **Backpressure:** hold `res_ready`=0 for 20 cycles → `res_*` stable and `busy`=1 throughout. Pulse `start` during this time → ignored. Raise `res_ready` → `busy`=0 on the next cycle.
- **Timeout:** with `TIMEOUT`=64, never assert `fp_valid` → `res_valid` with `res_class`=4'hF, `timeout_err`=1 exactly 64 cycles after WAIT entry. Assert `fp_valid` on the final count cycle instead → normal result with `timeout_err`=0.
- **Mid-stream reset:** assert `rst` at pixel 400 → next cycle all outputs are 0 and the FSM is in IDLE. A subsequent `start` repeats the stream check exactly.
- **Spurious result strobe:** pulse `fp_valid` during STREAM → ignored, and `res_scores` is unchanged until a WAIT-state capture.

Source files
------------

// File: rtl/forward_pass_sequencer_if.sv
// Bundle of every non-clock signal around the forward-pass sequencer.
//   master : the sequencer's view (drives memory reads, datapath strobes, results)
//   slave  : the environment's view (image memory, datapath, result consumer)
// Signals:
//   start/busy                      - inference request and activity flag
//   mem_rd_en/mem_addr/mem_rd_data  - synchronous image memory read port
//   fp_*                            - pixel stream to the datapath, fp_valid/fp_out back
//   res_*/timeout_err               - result handshake towards the consumer
interface forward_pass_sequencer_if #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned NUM_CLASS = 10,
    parameter int unsigned SCORE_W   = 16
);
    logic                           start;
    logic                           busy;
    logic                           mem_rd_en;
    logic [ADDR_W-1:0]              mem_addr;
    logic [7:0]                     mem_rd_data;
    logic [7:0]                     fp_ima;
    logic                           fp_ena;
    logic                           fp_frame_start;
    logic                           fp_line_start;
    logic                           fp_frame_end;
    logic                           fp_frame_start_dim;
    logic                           fp_frame_end_dim;
    logic                           fp_valid;
    logic [NUM_CLASS*SCORE_W-1:0]   fp_out;
    logic                           res_valid;
    logic                           res_ready;
    logic [3:0]                     res_class;
    logic [SCORE_W-1:0]             res_score;
    logic [NUM_CLASS*SCORE_W-1:0]   res_scores;
    logic                           timeout_err;

    modport master (
        input  start, mem_rd_data, fp_valid, fp_out, res_ready,
        output busy, mem_rd_en, mem_addr, fp_ima, fp_ena, fp_frame_start, fp_line_start,
               fp_frame_end, fp_frame_start_dim, fp_frame_end_dim, res_valid, res_class,
               res_score, res_scores, timeout_err
    );

    modport slave (
        output start, mem_rd_data, fp_valid, fp_out, res_ready,
        input  busy, mem_rd_en, mem_addr, fp_ima, fp_ena, fp_frame_start, fp_line_start,
               fp_frame_end, fp_frame_start_dim, fp_frame_end_dim, res_valid, res_class,
               res_score, res_scores, timeout_err
    );
endinterface

// File: rtl/forward_pass_sequencer.sv
// Frame-level controller for the CNN forward pass. Reads one IMG_W x IMG_H 8-bit image
// from a synchronous memory, streams it to the datapath with frame/line strobes, waits
// for the class-score vector (with a watchdog), reduces it to an argmax class one
// comparison per cycle and presents the result on a valid/ready handshake.
// Ports:
//   clk    - clock
//   rst    - synchronous active-high reset
//   fp_bus - master side of forward_pass_sequencer_if (memory, datapath, result)
module forward_pass_sequencer #(
    parameter int unsigned IMG_W     = 28,
    parameter int unsigned IMG_H     = 28,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned NUM_CLASS = 10,
    parameter int unsigned SCORE_W   = 16,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    forward_pass_sequencer_if.master fp_bus
);
    localparam int unsigned ColW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RowW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
    localparam int unsigned VecW = NUM_CLASS * SCORE_W;

    localparam logic [ColW-1:0] LastCol   = ColW'(IMG_W - 1);
    localparam logic [RowW-1:0] LastRow   = RowW'(IMG_H - 1);
    localparam logic [TmoW-1:0] LastCount = TmoW'(TIMEOUT - 1);
    localparam logic [3:0]      LastClass = 4'(NUM_CLASS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StStream,
        StPost,
        StWait,
        StArgmax,
        StHold
    } state_e;

    state_e              state_q, state_d;

    // Read side: address plus column/row position of the read in flight.
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ColW-1:0]     col_q, col_d;
    logic [RowW-1:0]     row_q, row_d;
    logic                last_rd;

    // Stage 1 tags travel alongside the memory latency; stage 2 drives the datapath.
    logic                s1_valid_q, s1_first_q, s1_line_q, s1_last_q;
    logic                ena_q, fs_q, ls_q, fe_q;
    logic [7:0]          ima_q;
    logic                fed_q, fed_d;

    // Result side.
    logic [TmoW-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic [VecW-1:0]     scores_q, scores_d;
    logic [3:0]          best_idx_q, best_idx_d;
    logic [SCORE_W-1:0]  best_score_q, best_score_d;
    logic [3:0]          arg_k_q, arg_k_d;
    logic                tmo_err_q, tmo_err_d;
    logic [SCORE_W-1:0]  cur_score;

    assign last_rd = (col_q == LastCol) && (row_q == LastRow);

    // Score currently under comparison in ARGMAX.
    always_comb begin
        cur_score = '0;
        for (int unsigned k = 0; k < NUM_CLASS; k++) begin
            if (arg_k_q == 4'(k)) begin
                cur_score = scores_q[k*SCORE_W +: SCORE_W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rd_en_d      = 1'b0;
        addr_d       = addr_q;
        col_d        = col_q;
        row_d        = row_q;
        fed_d        = 1'b0;
        tmo_cnt_d    = tmo_cnt_q;
        scores_d     = scores_q;
        best_idx_d   = best_idx_q;
        best_score_d = best_score_q;
        arg_k_d      = arg_k_q;
        tmo_err_d    = tmo_err_q;

        // Keep issuing sequential reads until the last pixel address has gone out.
        if (rd_en_q && !last_rd) begin
            rd_en_d = 1'b1;
            addr_d  = addr_q + 1'b1;
            if (col_q == LastCol) begin
                col_d = '0;
                row_d = (row_q == LastRow) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (fp_bus.start) begin
                    state_d   = StPre;
                    rd_en_d   = 1'b1;
                    addr_d    = '0;
                    col_d     = '0;
                    row_d     = '0;
                    tmo_err_d = 1'b0;
                end
            end
            StPre: begin
                state_d = StStream;
            end
            StStream: begin
                // Leave once the last pixel is on the datapath outputs.
                if (fe_q) begin
                    state_d = StPost;
                    fed_d   = 1'b1;
                end
            end
            StPost: begin
                state_d   = StWait;
                tmo_cnt_d = '0;
            end
            StWait: begin
                // A result on the final count still wins over the timeout.
                if (fp_bus.fp_valid) begin
                    state_d      = StArgmax;
                    scores_d     = fp_bus.fp_out;
                    best_idx_d   = '0;
                    best_score_d = fp_bus.fp_out[SCORE_W-1:0];
                    arg_k_d      = '0;
                end else if (tmo_cnt_q == LastCount) begin
                    state_d      = StHold;
                    tmo_err_d    = 1'b1;
                    best_idx_d   = 4'hF;
                    best_score_d = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            StArgmax: begin
                // Strictly greater only, so ties keep the lower index.
                if ($signed(cur_score) > $signed(best_score_q)) begin
                    best_idx_d   = arg_k_q;
                    best_score_d = cur_score;
                end
                if (arg_k_q == LastClass) begin
                    state_d = StHold;
                end else begin
                    arg_k_d = arg_k_q + 1'b1;
                end
            end
            StHold: begin
                if (fp_bus.res_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            rd_en_q      <= 1'b0;
            addr_q       <= '0;
            col_q        <= '0;
            row_q        <= '0;
            s1_valid_q   <= 1'b0;
            s1_first_q   <= 1'b0;
            s1_line_q    <= 1'b0;
            s1_last_q    <= 1'b0;
            ena_q        <= 1'b0;
            fs_q         <= 1'b0;
            ls_q         <= 1'b0;
            fe_q         <= 1'b0;
            ima_q        <= '0;
            fed_q        <= 1'b0;
            tmo_cnt_q    <= '0;
            scores_q     <= '0;
            best_idx_q   <= '0;
            best_score_q <= '0;
            arg_k_q      <= '0;
            tmo_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_en_q      <= rd_en_d;
            addr_q       <= addr_d;
            col_q        <= col_d;
            row_q        <= row_d;
            s1_valid_q   <= rd_en_q;
            s1_first_q   <= rd_en_q && (addr_q == '0);
            s1_line_q    <= rd_en_q && (col_q == '0);
            s1_last_q    <= rd_en_q && last_rd;
            ena_q        <= s1_valid_q;
            fs_q         <= s1_first_q;
            ls_q         <= s1_line_q;
            fe_q         <= s1_last_q;
            if (s1_valid_q) begin
                ima_q <= fp_bus.mem_rd_data;
            end
            fed_q        <= fed_d;
            tmo_cnt_q    <= tmo_cnt_d;
            scores_q     <= scores_d;
            best_idx_q   <= best_idx_d;
            best_score_q <= best_score_d;
            arg_k_q      <= arg_k_d;
            tmo_err_q    <= tmo_err_d;
        end
    end

    assign fp_bus.busy               = (state_q != StIdle);
    assign fp_bus.mem_rd_en          = rd_en_q;
    assign fp_bus.mem_addr           = addr_q;
    assign fp_bus.fp_ima             = ima_q;
    assign fp_bus.fp_ena             = ena_q;
    assign fp_bus.fp_frame_start     = fs_q;
    assign fp_bus.fp_line_start      = ls_q;
    assign fp_bus.fp_frame_end       = fe_q;
    // Stage-1 tag of pixel 0 lands exactly one cycle before pixel 0 is driven.
    assign fp_bus.fp_frame_start_dim = s1_first_q;
    assign fp_bus.fp_frame_end_dim   = fed_q;
    assign fp_bus.res_valid          = (state_q == StHold);
    assign fp_bus.res_class          = best_idx_q;
    assign fp_bus.res_score          = best_score_q;
    assign fp_bus.res_scores         = scores_q;
    assign fp_bus.timeout_err        = tmo_err_q;

endmodule

// File: tb/tb_forward_pass_sequencer.sv
module tb_forward_pass_sequencer;
    localparam int NPIX = 28 * 28;
    localparam int TMO  = 64;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   n_lines;

    logic [159:0] vec_a;
    logic [159:0] vec_b;
    logic [159:0] junk;

    forward_pass_sequencer_if #(.ADDR_W(10), .NUM_CLASS(10), .SCORE_W(16)) bus ();

    forward_pass_sequencer #(
        .IMG_W    (28),
        .IMG_H    (28),
        .ADDR_W   (10),
        .NUM_CLASS(10),
        .SCORE_W  (16),
        .TIMEOUT  (TMO)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .fp_bus(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Image memory: pixel = addr mod 256, one-cycle read latency.
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= bus.mem_addr[7:0];
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_v(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk_b({tag, "_busy"}, bus.busy, 1'b0);
        chk_b({tag, "_rd_en"}, bus.mem_rd_en, 1'b0);
        chk_v({tag, "_addr"}, 160'(bus.mem_addr), 160'(0));
        chk_v({tag, "_ima"}, 160'(bus.fp_ima), 160'(0));
        chk_b({tag, "_ena"}, bus.fp_ena, 1'b0);
        chk_b({tag, "_fs"}, bus.fp_frame_start, 1'b0);
        chk_b({tag, "_ls"}, bus.fp_line_start, 1'b0);
        chk_b({tag, "_fe"}, bus.fp_frame_end, 1'b0);
        chk_b({tag, "_fsd"}, bus.fp_frame_start_dim, 1'b0);
        chk_b({tag, "_fed"}, bus.fp_frame_end_dim, 1'b0);
        chk_b({tag, "_res_valid"}, bus.res_valid, 1'b0);
        chk_v({tag, "_res_class"}, 160'(bus.res_class), 160'(0));
        chk_v({tag, "_res_score"}, 160'(bus.res_score), 160'(0));
        chk_v({tag, "_res_scores"}, bus.res_scores, 160'(0));
        chk_b({tag, "_tmo_err"}, bus.timeout_err, 1'b0);
    endtask

    // Starts a frame from IDLE and checks every cycle up to WAIT entry (S+N+4).
    // A nonzero spur_j pulses fp_valid with junk scores while observing that cycle.
    task automatic run_stream(input int spur_j);
        logic ena_exp;
        n_lines = 0;
        bus.start = 1'b1;
        for (int j = 1; j <= NPIX + 4; j++) begin
            tick();
            bus.start    = 1'b0;
            bus.fp_valid = (j == spur_j);
            if (j == spur_j) bus.fp_out = junk;
            ena_exp = (j >= 3) && (j <= NPIX + 2);
            chk_b("s_busy", bus.busy, 1'b1);
            chk_b("s_rd_en", bus.mem_rd_en, j <= NPIX);
            if (j <= NPIX) chk_v("s_addr", 160'(bus.mem_addr), 160'(j - 1));
            chk_b("s_fsd", bus.fp_frame_start_dim, j == 2);
            chk_b("s_ena", bus.fp_ena, ena_exp);
            if (ena_exp) chk_v("s_ima", 160'(bus.fp_ima), 160'((j - 3) % 256));
            chk_b("s_fs", bus.fp_frame_start, j == 3);
            chk_b("s_ls", bus.fp_line_start, ena_exp && ((j - 3) % 28 == 0));
            chk_b("s_fe", bus.fp_frame_end, j == NPIX + 2);
            chk_b("s_fed", bus.fp_frame_end_dim, j == NPIX + 3);
            if (bus.fp_line_start) n_lines++;
        end
        bus.fp_valid = 1'b0;
        chk_v("s_line_count", 160'(n_lines), 160'(28));
        chk_b("s_wait_no_result", bus.res_valid, 1'b0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        vec_a = {16'd1, 16'h8000, 16'h0000, 16'h0000, 16'h0000,
                 16'h7FFF, 16'd2, 16'h7FFF, 16'd3, 16'hFFFB};
        vec_b = {16'h8001, {9{16'h8000}}};
        junk  = {10{16'h1234}};
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.fp_valid    = 1'b0;
        bus.fp_out      = '0;
        bus.res_ready   = 1'b0;
        bus.mem_rd_data = '0;
        repeat (3) tick();
        chk_zero("reset");
        rst = 1'b0;
        repeat (5) tick();

        // Stream, then argmax with tied maxima at classes 2 and 4.
        run_stream(0);
        bus.fp_valid = 1'b1;
        bus.fp_out   = vec_a;
        tick();
        bus.fp_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            chk_b("am_not_yet", bus.res_valid, 1'b0);
            tick();
        end
        // Backpressure with a stray start that must be dropped.
        for (int i = 0; i < 20; i++) begin
            bus.start = (i == 5);
            chk_b("bp_valid", bus.res_valid, 1'b1);
            chk_v("bp_class", 160'(bus.res_class), 160'(2));
            chk_v("bp_score", 160'(bus.res_score), 160'(16'h7FFF));
            chk_b("bp_tmo", bus.timeout_err, 1'b0);
            chk_b("bp_busy", bus.busy, 1'b1);
            chk_v("bp_scores", bus.res_scores, vec_a);
            tick();
        end
        bus.start     = 1'b0;
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk_b("hs_busy", bus.busy, 1'b0);
        chk_b("hs_valid", bus.res_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_b("no_queue_busy", bus.busy, 1'b0);
            chk_b("no_queue_rd", bus.mem_rd_en, 1'b0);
        end

        // Mid-stream reset at pixel 400, then an identical stream.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (402) tick();
        chk_b("mid_ena", bus.fp_ena, 1'b1);
        chk_v("mid_ima", 160'(bus.fp_ima), 160'(144));
        rst = 1'b1;
        tick();
        chk_zero("midrst");
        rst = 1'b0;
        run_stream(0);
        // Result on the final count cycle beats the timeout.
        repeat (TMO - 1) tick();
        chk_b("edge_not_yet", bus.res_valid, 1'b0);
        bus.fp_valid = 1'b1;
        bus.fp_out   = vec_b;
        tick();
        bus.fp_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            chk_b("edge_wait", bus.res_valid, 1'b0);
            tick();
        end
        chk_b("edge_valid", bus.res_valid, 1'b1);
        chk_b("edge_tmo", bus.timeout_err, 1'b0);
        chk_v("edge_class", 160'(bus.res_class), 160'(9));
        chk_v("edge_score", 160'(bus.res_score), 160'(16'h8001));
        chk_v("edge_scores", bus.res_scores, vec_b);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk_b("edge_hs_busy", bus.busy, 1'b0);

        // Spurious strobe during stream, then a genuine timeout.
        run_stream(100);
        chk_v("spur_scores", bus.res_scores, vec_b);
        for (int i = 0; i < TMO; i++) begin
            chk_b("tmo_not_yet", bus.res_valid, 1'b0);
            chk_b("tmo_err_low", bus.timeout_err, 1'b0);
            tick();
        end
        chk_b("tmo_valid", bus.res_valid, 1'b1);
        chk_b("tmo_err", bus.timeout_err, 1'b1);
        chk_v("tmo_class", 160'(bus.res_class), 160'(15));
        chk_v("tmo_score", 160'(bus.res_score), 160'(0));
        chk_v("tmo_scores", bus.res_scores, vec_b);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk_b("tmo_hs_busy", bus.busy, 1'b0);
        chk_b("tmo_hs_valid", bus.res_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
